keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner_if.sv | 10 +
 rtl/keypad_scanner.sv | 88 ++++++++
 tb/tb_keypad_scanner.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pin and decoded-key bundle between scanner and keypad/display side
interface keypad_scanner_if;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] key;
   logic       key_valid;
   logic       key_held;
   modport master(input rows, output cols, key, key_valid, key_held);
   modport slave(output rows, input cols, key, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low keypad scan, debounce and hex decode; define KEYPAD_SYNC_EN for a 2-flop row synchronizer
module keypad_scanner #(
   parameter int SCAN_DIV        = 4,
   parameter int DEBOUNCE_CYCLES = 8
) (
   input logic              clk,
   input logic              reset,
   keypad_scanner_if.master kp
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
   state_t        state;
   logic [1:0]    c, r, next_c, low_row;
   logic [CW-1:0] col_cnt;
   logic [DW-1:0] db_cnt;
   logic [3:0]    rows_s, pressed;
   logic          match, col_done, db_done;
`ifdef KEYPAD_SYNC_EN
   logic [3:0] sync1;
   always_ff @(posedge clk)
      if (reset) {rows_s, sync1} <= 8'hff;
      else {rows_s, sync1} <= {sync1, kp.rows};
`else
   assign rows_s = kp.rows;
`endif
   always_comb begin
      pressed  = ~rows_s;
      low_row  = pressed[0] ? 2'd0 : pressed[1] ? 2'd1 : pressed[2] ? 2'd2 : 2'd3;
      match    = rows_s == ~(4'b0001 << r);
      next_c   = c + 2'd1;
      col_done = col_cnt == CW'(SCAN_DIV - 1);
      db_done  = db_cnt == DW'(DEBOUNCE_CYCLES - 1);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= SCAN;
         c            <= 2'd0;
         r            <= 2'd0;
         col_cnt      <= '0;
         db_cnt       <= '0;
         kp.cols      <= 4'b1110;
         kp.key       <= 4'h0;
         kp.key_valid <= 1'b0;
         kp.key_held  <= 1'b0;
      end else begin
         kp.key_valid <= 1'b0;
         case (state)
            SCAN:
               if (!col_done) col_cnt <= col_cnt + 1'b1;
               else if (|pressed) begin
                  r      <= low_row;
                  db_cnt <= '0;
                  state  <= DEBOUNCE;
               end else begin
                  c       <= next_c;
                  kp.cols <= ~(4'b0001 << next_c);
                  col_cnt <= '0;
               end
            DEBOUNCE:
               if (!match) begin
                  col_cnt <= '0;
                  state   <= SCAN;
               end else if (db_done) begin
                  kp.key       <= KEY_MAP[{r, c, 2'b00} +: 4];
                  kp.key_valid <= 1'b1;
                  kp.key_held  <= 1'b1;
                  state        <= HELD;
               end else db_cnt <= db_cnt + 1'b1;
            HELD:
               if (rows_s[r]) begin
                  db_cnt <= '0;
                  state  <= RELEASE;
               end
            RELEASE:
               if (!rows_s[r]) state <= HELD;
               else if (db_done) begin
                  kp.key_held <= 1'b0;
                  c           <= next_c;
                  kp.cols     <= ~(4'b0001 << next_c);
                  col_cnt     <= '0;
                  state       <= SCAN;
               end else db_cnt <= db_cnt + 1'b1;
         endcase
      end
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model with randomized presses/bounces; strobes checked by a scoreboard monitor
module tb_keypad_scanner;
   localparam int DEB = 8;
`ifdef KEYPAD_SYNC_EN
   localparam int SD = 2;
`else
   localparam int SD = 0;
`endif
   logic clk = 1'b0, reset = 1'b1;
   logic [15:0] kmask = '0;
   int total = 0, bad = 0;
   int key_tab [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
   int exp_q [$];
   logic prev_valid = 1'b0;
   keypad_scanner_if kp();
   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(DEB)) dut (.clk(clk), .reset(reset), .kp(kp.master));
   always #5 clk = ~clk;
   always_comb begin
      kp.rows = 4'hf;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (kmask[r*4+c] && !kp.cols[c]) kp.rows[r] = 1'b0;
   end
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [3:0] col_drive(input int c);
      logic [3:0] e;
      e = 4'hf;
      e[c] = 1'b0;
      return e;
   endfunction
   always @(negedge clk) begin
      if (kp.key_valid) begin
         chk("strobe_width", int'(prev_valid), 0);
         if (exp_q.size() == 0) chk("unexpected_strobe", int'(kp.key), -1);
         else chk("strobe_key", int'(kp.key), exp_q.pop_front());
      end
      prev_valid = kp.key_valid;
   end
   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end
   task automatic press(input int r, input int c);
      kmask[r*4+c] = 1'b1;
      exp_q.push_back(key_tab[r][c]);
   endtask
   initial begin
      int lat, r, c, n;
      // reset values and free-running column sweep
      repeat (3) tick();
      chk("rst_cols", int'(kp.cols), 4'b1110);
      chk("rst_key", int'(kp.key), 0);
      chk("rst_valid", int'(kp.key_valid), 0);
      chk("rst_held", int'(kp.key_held), 0);
      reset = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         tick();
         chk("sweep_cols", int'(kp.cols), int'(col_drive((k / 4) % 4)));
      end
      // press latency from a known scan phase: '4' at column 0 right after reset
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      press(1, 0);
      lat = 0;
      while (!kp.key_valid && lat < 40) begin tick(); lat++; end
      chk("press_latency", lat, 12);
      repeat (20) tick();
      kmask = '0;
      lat = 0;
      while (kp.key_held && lat < 40) begin tick(); lat++; end
      chk("release_latency", lat, DEB + SD + 1);
      chk("resume_col1", int'(kp.cols), 4'b1101);
      repeat (10) tick();
      // clean '6'
      press(1, 2);
      repeat (200) tick();
      chk("six_key", int'(kp.key), 6);
      chk("six_held", int'(kp.key_held), 1);
      kmask = '0;
      repeat (40) tick();
      chk("six_released", int'(kp.key_held), 0);
      chk("six_key_kept", int'(kp.key), 6);
      // bouncing 'A'
      for (int j = 0; j < 10; j++) begin
         kmask[3] = ~kmask[3];
         repeat (3) tick();
      end
      press(0, 3);
      repeat (100) tick();
      chk("a_key", int'(kp.key), 10);
      kmask = '0;
      repeat (40) tick();
      // release glitch on '0'
      press(3, 1);
      repeat (60) tick();
      chk("zero_held", int'(kp.key_held), 1);
      kmask = '0;
      repeat (5) tick();
      kmask[13] = 1'b1;
      repeat (30) tick();
      chk("zero_still_held", int'(kp.key_held), 1);
      kmask = '0;
      lat = 0;
      while (kp.key_held && lat < 40) begin tick(); lat++; end
      chk("zero_release_latency", lat, DEB + SD + 1);
      chk("resume_col2", int'(kp.cols), 4'b1011);
      chk("zero_key", int'(kp.key), 0);
      repeat (20) tick();
      // second key while '1' is held
      press(0, 0);
      repeat (60) tick();
      kmask[10] = 1'b1;
      repeat (60) tick();
      chk("one_key", int'(kp.key), 1);
      chk("one_held", int'(kp.key_held), 1);
      kmask = '0;
      repeat (40) tick();
      // reset while debouncing '5'
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      kmask[5] = 1'b1;
      repeat (11) tick();
      chk("db_col_hold", int'(kp.cols), 4'b1101);
      reset = 1'b1;
      tick();
      chk("mid_rst_cols", int'(kp.cols), 4'b1110);
      chk("mid_rst_key", int'(kp.key), 0);
      chk("mid_rst_valid", int'(kp.key_valid), 0);
      chk("mid_rst_held", int'(kp.key_held), 0);
      kmask = '0;
      tick();
      reset = 1'b0;
      repeat (40) tick();
      chk("mid_rst_no_key", int'(kp.key), 0);
      // randomized presses with optional bounce and release glitches
      for (int i = 0; i < 12; i++) begin
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) begin
            n = $urandom_range(6, 12);
            for (int j = 0; j < n; j++) begin
               kmask[r*4+c] = ~kmask[r*4+c];
               repeat ($urandom_range(1, 3)) tick();
            end
         end
         press(r, c);
         repeat ($urandom_range(60, 120)) tick();
         chk("rnd_key", int'(kp.key), key_tab[r][c]);
         chk("rnd_held", int'(kp.key_held), 1);
         if ($urandom_range(0, 1) == 1) begin
            kmask = '0;
            repeat ($urandom_range(1, 5)) tick();
            kmask[r*4+c] = 1'b1;
            repeat (20) tick();
         end
         kmask = '0;
         repeat (40) tick();
         chk("rnd_released", int'(kp.key_held), 0);
      end
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
